// File: rtl/game_status_pkg.sv
// Shared types and seven-segment constants for the game status display driver.
package game_status_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } game_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit 0 = a ... bit 6 = g; non-BCD codes go blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern with a blank override.
module seg7_decode
  import game_status_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) seg_o = bcd_to_seg(bcd_i);
  end

endmodule

// File: rtl/game_status_hex.sv
// Score / game-status driver: BCD score counter, game FSM, blink timer, HEX and LED registers.
// Build option GAME_STATUS_LZ_BLANK_EN enables leading-zero blanking on the score display.
module game_status_hex
  import game_status_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 6,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    inc,
  input  logic                    clr,
  input  logic                    done,
  input  logic                    victory,
  output logic [N_DIGITS*7-1:0]   hex,
  output logic [N_DIGITS*4-1:0]   score_bcd,
  output logic [1:0]              state,
  output logic                    led_defeat,
  output logic                    led_victory
);

  localparam int unsigned SCORE_W = N_DIGITS * 4;
  localparam int unsigned HEX_W   = N_DIGITS * 7;
  localparam int unsigned CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {N_DIGITS{4'h9}};

  game_state_e          state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [HEX_W-1:0]     hex_q, hex_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic                 led_defeat_q, led_defeat_d;
  logic                 led_victory_q, led_victory_d;
  logic                 carry;
  logic [N_DIGITS-1:0]  dig_blank;

  // Game state transitions; done wins over victory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = PLAY;
      PLAY: begin
        if (done)         state_d = LOST;
        else if (victory) state_d = WON;
      end
      WON, LOST: if (clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating BCD ripple increment in PLAY; clr zeroes outside PLAY.
  always_comb begin
    score_d = score_q;
    carry   = 1'b1;
    if (state_q == PLAY) begin
      if (inc && (score_q != SCORE_MAX)) begin
        for (int i = 0; i < int'(N_DIGITS); i++) begin
          if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
              score_d[4*i +: 4] = 4'd0;
            end else begin
              score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
              carry             = 1'b0;
            end
          end
        end
      end
    end else if (clr) begin
      score_d = '0;
    end
  end

  // Blink timer restarts visible on every entry into WON.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if ((state_q != WON) && (state_d == WON)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // LEDs follow the upcoming state so they line up with the state output.
  always_comb begin
    led_defeat_d  = (state_d == LOST);
    led_victory_d = (state_d == WON) && phase_d;
  end

  // Per-digit blanking: optional leading zeros, and the WON off-phase.
`ifdef GAME_STATUS_LZ_BLANK_EN
  logic seen_nz;
  always_comb begin
    dig_blank = '0;
    seen_nz   = 1'b0;
    for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
      seen_nz      = seen_nz | (score_q[4*k +: 4] != 4'd0);
      dig_blank[k] = ~seen_nz;
    end
    if ((state_q == WON) && !phase_q) dig_blank = '1;
  end
`else
  always_comb begin
    dig_blank = '0;
    if ((state_q == WON) && !phase_q) dig_blank = '1;
  end
`endif

  for (genvar g = 0; g < int'(N_DIGITS); g++) begin : g_dec
    seg7_decode u_dec (
      .bcd_i   (score_q[4*g +: 4]),
      .blank_i (dig_blank[g]),
      .seg_o   (hex_d[7*g +: 7])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      score_q       <= '0;
      hex_q         <= '1;
      cnt_q         <= '0;
      phase_q       <= 1'b1;
      led_defeat_q  <= 1'b0;
      led_victory_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      hex_q         <= hex_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      led_defeat_q  <= led_defeat_d;
      led_victory_q <= led_victory_d;
    end
  end

  assign hex         = hex_q;
  assign score_bcd   = score_q;
  assign state       = 2'(state_q);
  assign led_defeat  = led_defeat_q;
  assign led_victory = led_victory_q;

endmodule

// File: doc/game_status_hex.md
Name: game_status_hex

Overview:
- Parametrised score and game-status display driver for the DE1-SoC top level.
- Replaces the hard-blanked HEX outputs and the bare defeat/victory GPIO LEDs with registered driving logic.
- Counts score events in BCD across N_DIGITS seven-segment displays.
- Tracks game state (idle/play/won/lost) and drives blinking victory and steady defeat indicators.
- Sits between gameDisplay (done, victory, score pulses) and the HEX/GPIO pins.

Parameters:
- N_DIGITS, 6, number of BCD digits / HEX displays driven (1..8).
- BLINK_DIV, 25_000_000, CLOCK_50 cycles per blink half-period (>=2).

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; leaves IDLE.
- inc  input  1  one-cycle pulse; adds 1 to score in PLAY.
- clr  input  1  level; returns WON/LOST to IDLE and zeroes score.
- done  input  1  level from game; defeat condition.
- victory  input  1  level from game; victory condition.
- hex  output  N_DIGITS*7  active-low segments; digit i at [7i+6:7i], digit 0 least significant.
- score_bcd  output  N_DIGITS*4  current score, BCD, digit 0 in [3:0].
- state  output  2  encoded game state.
- led_defeat  output  1  defeat indicator (GPIO).
- led_victory  output  1  victory indicator (GPIO).

Behaviour:
- Reset:
  - state=IDLE, score_bcd=0, hex all ones (blank), led_defeat=0, led_victory=0.
  - Blink counter=0, blink phase=1 (visible).
- State machine, registered:
  - IDLE -> PLAY when start=1.
  - PLAY -> LOST when done=1. done has priority if done and victory are both 1 in the same cycle.
  - PLAY -> WON when victory=1 and done=0.
  - WON or LOST -> IDLE when clr=1; score zeroed in that same edge.
  - clr in IDLE zeroes score. clr in PLAY is ignored.
- Score:
  - In PLAY with inc=1, score increments by 1 in BCD with ripple carry: digit 9 -> 0 and carries into the next digit.
  - Saturates at all-9s; no wrap.
  - inc is ignored outside PLAY. An inc in the same cycle as a PLAY->WON/LOST transition is still counted.
  - score_bcd is valid 1 cycle after inc.
  - hex is registered and reflects the new score 2 cycles after inc.
- Display:
  - IDLE: hex shows the score, which is 0 after reset or clr.
  - PLAY and LOST: hex shows the score, steady.
  - WON: hex shows the score when blink phase=1 and all-blank when blink phase=0.
  - Non-BCD digit codes cannot occur; the decoder maps them to blank.
- Blink timer:
  - Counter runs 0..BLINK_DIV-1 and toggles blink phase on wrap.
  - Forced to count 0 and phase 1 on any entry into WON, so the first half-period is visible and lasts exactly BLINK_DIV cycles.
- LEDs, registered:
  - led_defeat=1 throughout LOST, otherwise 0.
  - led_victory=blink phase in WON, otherwise 0.
- Reset asserted mid-game returns everything to reset values on the next edge, regardless of the other inputs.

Optional Feature:
- Macro: GAME_STATUS_LZ_BLANK_EN.
- Defined: leading-zero blanking. Any digit above the most significant nonzero digit is driven blank; digit 0 is always shown, so a score of 0 displays a single "0".
- Undefined: all N_DIGITS digits are always shown, zeros included.
- Blink and state behaviour are identical in both builds.

Decomposition:
- Package game_status_pkg:
  - state enum: IDLE=2'd0, PLAY=2'd1, WON=2'd2, LOST=2'd3.
  - SEG_BLANK=7'h7F.
  - Active-low segment codes for 0-9.
- Sub-module seg7_decode: combinational 4-bit BCD to 7-segment, with a blank input. Instantiated per digit by generate.
- BCD counter, state machine and blink timer live in game_status_hex.

Test Plan:
1. Reset with N_DIGITS=4, BLINK_DIV=4 -> state=0, hex=28'hFFFFFFF, both LEDs 0.
2. start, then 12 inc pulses -> score_bcd=16'h0012; hex digit0=7'b0100100 ("2") and digit1=7'b1111001 ("1") 2 cycles after the last inc.
3. Preload 9999 via inc pulses, one more inc -> score_bcd stays 16'h9999, no wrap.
4. In PLAY, raise done and victory in the same cycle -> state=LOST, led_defeat=1, led_victory=0; further inc pulses leave the score unchanged.
5. Victory in PLAY -> state=WON; hex visible for 4 cycles, blank for 4 cycles, repeating; led_victory tracks the phase; clr -> IDLE, score 0.
6. Reset asserted during WON blink-off phase -> next edge gives IDLE, blank hex, LEDs 0. With GAME_STATUS_LZ_BLANK_EN defined and score 0005 -> digits 3..1 are 7'h7F and digit 0 shows "5".
